// File: rtl/page_transfer_scheduler.sv
// Round-robin scheduler handing one flash path to a page writer or reader and pacing the transfer by per-page acks.
// Every output is registered: grant one edge after a request, start one edge after ready, Done/Error one edge after the terminal state.
module page_transfer_scheduler #(
  parameter int unsigned CNT_W     = 12,
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter int unsigned READY_BIT = 6
) (
  input  logic             CLK,
  input  logic             nReset,
  input  logic             WrReq,
  input  logic [CNT_W-1:0] WrPages,
  input  logic             RdReq,
  input  logic [CNT_W-1:0] RdPages,
  input  logic [7:0]       StatusReg,
  input  logic             AckWr,
  input  logic             AckRd,
  output logic             WrStart,
  output logic             RdStart,
  output logic             WrGrant,
  output logic             RdGrant,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] PageCnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    START    = 3'd2,
    XFER     = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  localparam logic [2:0] RDY_IDX = 3'(READY_BIT);

  state_t           r_state;
  logic             r_dir_rd;
  logic             r_last_rd;
  logic [CNT_W-1:0] r_len;
  logic [15:0]      r_tmo;
  logic [CNT_W-1:0] r_page_cnt;
  logic             r_wr_grant;
  logic             r_rd_grant;
  logic             r_wr_start;
  logic             r_rd_start;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  state_t           w_state_nxt;
  logic             w_dir_rd_nxt;
  logic             w_last_rd_nxt;
  logic [CNT_W-1:0] w_len_nxt;
  logic [15:0]      w_tmo_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_grant_nxt;
  logic             w_wr_start_nxt;
  logic             w_rd_start_nxt;
  logic             w_done_nxt;
  logic             w_error_nxt;

  logic             w_ready;
  logic             w_pick_rd;
  logic [CNT_W-1:0] w_req_pages;
  logic             w_ack;
  logic [15:0]      w_tmo_inc;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tmo_hit;
  logic             w_unused_status;

  assign w_ready         = StatusReg[RDY_IDX];
  assign w_unused_status = ^StatusReg;
  // On a tie the side that did not own the path last time wins
  assign w_pick_rd   = RdReq & (~WrReq | ~r_last_rd);
  assign w_req_pages = w_pick_rd ? RdPages : WrPages;
  assign w_ack       = r_dir_rd ? AckRd : AckWr;
  assign w_tmo_inc   = r_tmo + 16'd1;
  assign w_tmo_hit   = (w_tmo_inc >= TIMEOUT);
  assign w_cnt_inc   = (&r_page_cnt) ? r_page_cnt : r_page_cnt + CNT_W'(1);

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_dir_rd_nxt   = r_dir_rd;
    w_last_rd_nxt  = r_last_rd;
    w_len_nxt      = r_len;
    w_tmo_nxt      = r_tmo;
    w_cnt_nxt      = r_page_cnt;
    w_grant_nxt    = r_wr_grant | r_rd_grant;
    w_wr_start_nxt = 1'b0;
    w_rd_start_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        if (WrReq || RdReq) begin
          w_dir_rd_nxt = w_pick_rd;
          w_len_nxt    = w_req_pages;
          w_cnt_nxt    = '0;
          w_tmo_nxt    = '0;
          w_grant_nxt  = 1'b1;
          w_state_nxt  = (w_req_pages == '0) ? ERR : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        w_tmo_nxt = w_tmo_inc;
        if (w_ready) begin
          w_state_nxt    = START;
          w_wr_start_nxt = ~r_dir_rd;
          w_rd_start_nxt = r_dir_rd;
        end else if (w_tmo_hit) begin
          w_state_nxt = ERR;
        end
      end
      START: begin
        w_state_nxt = XFER;
      end
      XFER: begin
        if (w_ack) begin
          w_tmo_nxt = '0;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_state_nxt = DONE;
          end
        end else begin
          w_tmo_nxt = w_tmo_inc;
          if (w_tmo_hit) begin
            w_state_nxt = ERR;
          end
        end
      end
      DONE: begin
        w_done_nxt    = 1'b1;
        w_grant_nxt   = 1'b0;
        w_last_rd_nxt = r_dir_rd;
        w_state_nxt   = IDLE;
      end
      ERR: begin
        w_error_nxt   = 1'b1;
        w_grant_nxt   = 1'b0;
        w_last_rd_nxt = r_dir_rd;
        w_state_nxt   = IDLE;
      end
      default: begin
        w_grant_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      r_dir_rd   <= 1'b0;
      r_last_rd  <= 1'b1;
      r_len      <= '0;
      r_tmo      <= '0;
      r_page_cnt <= '0;
      r_wr_grant <= 1'b0;
      r_rd_grant <= 1'b0;
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_dir_rd   <= w_dir_rd_nxt;
      r_last_rd  <= w_last_rd_nxt;
      r_len      <= w_len_nxt;
      r_tmo      <= w_tmo_nxt;
      r_page_cnt <= w_cnt_nxt;
      r_wr_grant <= w_grant_nxt & ~w_dir_rd_nxt;
      r_rd_grant <= w_grant_nxt & w_dir_rd_nxt;
      r_wr_start <= w_wr_start_nxt;
      r_rd_start <= w_rd_start_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign WrStart = r_wr_start;
  assign RdStart = r_rd_start;
  assign WrGrant = r_wr_grant;
  assign RdGrant = r_rd_grant;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Error   = r_error;
  assign PageCnt = r_page_cnt;

endmodule

// File: tb/tb_page_transfer_scheduler.sv
// Scoreboard bench: the driver predicts each transfer's outcome from the arbitration rules, a monitor checks every Done/Error.
module tb_page_transfer_scheduler;
  localparam int          CNT_W = 4;
  localparam logic [15:0] TMO   = 16'd16;
  localparam int          RB    = 6;

  logic             CLK = 1'b0;
  logic             nReset = 1'b0;
  logic             WrReq = 1'b0, RdReq = 1'b0;
  logic [CNT_W-1:0] WrPages = '0, RdPages = '0;
  logic [7:0]       StatusReg = '0;
  logic             AckWr = 1'b0, AckRd = 1'b0;
  logic             WrStart, RdStart, WrGrant, RdGrant, Busy, Done, Error;
  logic [CNT_W-1:0] PageCnt;

  page_transfer_scheduler #(.CNT_W(CNT_W), .TIMEOUT(TMO), .READY_BIT(RB)) dut (
    .CLK(CLK), .nReset(nReset), .WrReq(WrReq), .WrPages(WrPages), .RdReq(RdReq),
    .RdPages(RdPages), .StatusReg(StatusReg), .AckWr(AckWr), .AckRd(AckRd),
    .WrStart(WrStart), .RdStart(RdStart), .WrGrant(WrGrant), .RdGrant(RdGrant),
    .Busy(Busy), .Done(Done), .Error(Error), .PageCnt(PageCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct { bit rd; bit err; int cnt; int nstart; } exp_t;
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_last_rd = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ready(input bit rdy);
    StatusReg     = 8'($urandom);
    StatusReg[RB] = rdy;
  endtask

  // Monitor: checks grant exclusivity each cycle and each transfer ending against the scoreboard
  initial begin : monitor
    bit   prev_g;
    bit   prev_rd;
    int   starts;
    exp_t e;
    prev_g = 1'b0; prev_rd = 1'b0; starts = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!nReset) begin
        prev_g = 1'b0;
        starts = 0;
      end else begin
        chk("grant_exclusive", int'(WrGrant & RdGrant), 0);
        if ((WrGrant || RdGrant) && !prev_g) starts = 0;
        if (WrStart || RdStart) starts++;
        if (Done || Error) begin
          chk("sb_pending", int'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("end_is_error", int'(Error), int'(e.err));
            chk("done_error_exclusive", int'(Done & Error), 0);
            chk("end_owner_rd", int'(prev_rd), int'(e.rd));
            chk("end_pagecnt", int'(PageCnt), e.cnt);
            chk("start_pulses", starts, e.nstart);
            chk("grant_dropped", int'(WrGrant | RdGrant), 0);
            chk("busy_dropped", int'(Busy), 0);
          end
        end
        prev_g = WrGrant | RdGrant;
        if (prev_g) prev_rd = RdGrant;
      end
    end
  end

  task automatic do_xfer(input bit wreq, input bit rreq, input int wp, input int rp,
                         input int rdy_dly, input bit stray);
    exp_t e;
    bit   rd;
    int   pages;
    int   n;
    int   gap;
    rd       = rreq && (!wreq || !m_last_rd);
    pages    = rd ? rp : wp;
    m_last_rd = rd;
    e.rd = rd; e.err = (pages == 0); e.cnt = pages; e.nstart = (pages != 0) ? 1 : 0;
    sb_q.push_back(e);
    WrPages = CNT_W'(wp); RdPages = CNT_W'(rp);
    WrReq = wreq; RdReq = rreq;
    set_ready(rdy_dly == 0);
    step();
    chk("grant_latency", int'(WrGrant | RdGrant), 1);
    chk("grant_owner_rd", int'(RdGrant), int'(rd));
    chk("pagecnt_cleared", int'(PageCnt), 0);
    chk("busy_on_grant", int'(Busy), 1);
    WrPages = CNT_W'($urandom); RdPages = CNT_W'($urandom);
    WrReq = 1'($urandom); RdReq = 1'($urandom);
    if (pages == 0) begin
      step();
      chk("zero_pages_error", int'(Error), 1);
    end else begin
      repeat (rdy_dly > 0 ? rdy_dly - 1 : 0) step();
      set_ready(1'b1);
      n = 0;
      while (!(WrStart || RdStart) && n < 10) begin
        step();
        n++;
      end
      chk("start_seen", int'(WrStart | RdStart), 1);
      chk("start_owner_rd", int'(RdStart), int'(rd));
      if (rdy_dly == 0) chk("start_latency", n, 1);
      if (stray) begin
        if (rd) AckRd = 1'b1; else AckWr = 1'b1;
      end
      step();
      AckWr = 1'b0; AckRd = 1'b0;
      chk("start_one_cycle", int'(WrStart | RdStart), 0);
      for (int p = 0; p < pages; p++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          if (rd) AckWr = stray & 1'($urandom); else AckRd = stray & 1'($urandom);
          step();
        end
        if (rd) begin AckRd = 1'b1; AckWr = stray & 1'($urandom); end
        else begin AckWr = 1'b1; AckRd = stray & 1'($urandom); end
        step();
        AckWr = 1'b0; AckRd = 1'b0;
      end
    end
    n = 0;
    while (!(Done || Error) && n < 10) begin
      step();
      n++;
    end
    chk("end_seen", int'(Done | Error), 1);
    WrReq = 1'b0; RdReq = 1'b0;
  endtask

  initial begin : driver
    exp_t e;
    int   n;
    int   sel;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wr_grant", int'(WrGrant), 0);
    chk("rst_rd_grant", int'(RdGrant), 0);
    chk("rst_starts", int'(WrStart | RdStart), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_error", int'(Error), 0);
    chk("rst_pagecnt", int'(PageCnt), 0);
    nReset = 1'b1;
    step();

    do_xfer(1'b1, 1'b0, 3, 0, 0, 1'b0);
    step();
    step();
    chk("pagecnt_hold_after_done", int'(PageCnt), 3);
    chk("busy_idle", int'(Busy), 0);

    do_xfer(1'b0, 1'b1, 0, 0, 0, 1'b0);
    do_xfer(1'b0, 1'b1, 0, 3, 2, 1'b1);
    do_xfer(1'b1, 1'b0, 15, 0, 0, 1'b0);

    // Stall after one ack of a read: the idle counter expires in XFER
    e.rd = 1'b1; e.err = 1'b1; e.cnt = 1; e.nstart = 1;
    sb_q.push_back(e);
    m_last_rd = 1'b1;
    RdReq = 1'b1; RdPages = 4'd3; set_ready(1'b1);
    step(); step(); step();
    RdReq = 1'b0;
    AckRd = 1'b1;
    step();
    AckRd = 1'b0;
    n = 0;
    while (!Error && n < 40) begin step(); n++; end
    chk("xfer_timeout_seen", int'(Error), 1);

    // Ready held low: Error 17 edges after grant (16 WAIT_RDY cycles, then the ERR cycle)
    e.rd = 1'b0; e.err = 1'b1; e.cnt = 0; e.nstart = 0;
    sb_q.push_back(e);
    m_last_rd = 1'b0;
    WrReq = 1'b1; WrPages = 4'd5; set_ready(1'b0);
    step();
    chk("tmo_grant", int'(WrGrant), 1);
    n = 0;
    while (!Error && n < 30) begin step(); n++; end
    chk("wait_rdy_timeout_latency", n, 17);
    WrReq = 1'b0;

    // Reset in the middle of a write: everything clears at once, no end pulse
    WrReq = 1'b1; WrPages = 4'd4; set_ready(1'b1);
    step(); step(); step();
    AckWr = 1'b1;
    step();
    AckWr = 1'b0;
    chk("mid_pagecnt", int'(PageCnt), 1);
    #2 nReset = 1'b0;
    #1;
    chk("mid_rst_grant", int'(WrGrant | RdGrant), 0);
    chk("mid_rst_busy", int'(Busy), 0);
    chk("mid_rst_pagecnt", int'(PageCnt), 0);
    chk("mid_rst_pulses", int'(Done | Error | WrStart | RdStart), 0);
    WrReq = 1'b0;
    m_last_rd = 1'b1;
    step(); step();
    nReset = 1'b1;
    step();

    do_xfer(1'b1, 1'b1, 2, 3, 0, 1'b0);
    do_xfer(1'b1, 1'b1, 1, 2, 1, 1'b0);

    repeat (60) begin
      sel = $urandom_range(0, 2);
      do_xfer(sel != 1, sel != 0, $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 3), 1'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/page_transfer_scheduler.md
PAGE_TRANSFER_SCHEDULER -- requirements
Module: page_transfer_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of the page-count ports and counters.
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, cycle limit without progress before abort.
REQ-003 SHALL have parameter READY_BIT, default 6, index of the flash-ready bit in StatusReg.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; these are the first two ports.
REQ-005 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-006 nReset  input  1  asynchronous active-low reset.
REQ-007 WrReq  input  1  write requester asks for a transfer (level).
REQ-008 WrPages  input  CNT_W  pages requested by the writer.
REQ-009 RdReq  input  1  read requester asks for a transfer (level).
REQ-010 RdPages  input  CNT_W  pages requested by the reader.
REQ-011 StatusReg  input  8  flash status; bit READY_BIT=1 means ready.
REQ-012 AckWr / AckRd  input  1 each  one-cycle per-page completion strobes from the address driver.
REQ-013 WrStart / RdStart  output  1 each  one-cycle start pulse to the address driver.
REQ-014 WrGrant / RdGrant  output  1 each  owner of the flash path; never both high.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 Done / Error  output  1 each  one-cycle completion / abort pulses.
REQ-017 PageCnt  output  CNT_W  pages acknowledged in the current transfer.

Function
REQ-018 SHALL use FSM states IDLE, WAIT_RDY, START, XFER, DONE, ERR.
REQ-019 IDLE: requests SHALL be sampled only in IDLE.
- If exactly one request is high, that requester SHALL be granted.
- If both are high, the requester not granted last SHALL win (round-robin); the last-granted flag resets to "read", so the writer wins the first tie.
REQ-020 On grant, the scheduler SHALL:
- latch the requester's page count;
- clear PageCnt and the timeout counter;
- assert the grant at the next edge;
- go to WAIT_RDY.
REQ-021 A latched page count of 0 SHALL go to ERR instead of WAIT_RDY; no start pulse SHALL be issued.
REQ-022 WAIT_RDY: when StatusReg[READY_BIT]=1, SHALL go to START.
REQ-023 START: SHALL assert the matching WrStart or RdStart for exactly one cycle, then go to XFER.
- Start therefore occurs 2 cycles after a request accepted with ready already high.
REQ-024 XFER: each matching ack (AckWr for a write, AckRd for a read) SHALL increment PageCnt and clear the timeout counter.
- Acks of the other direction, and acks in any other state, SHALL be ignored.
REQ-025 When the incremented PageCnt equals the latched count, SHALL go to DONE.
REQ-026 DONE: SHALL pulse Done for one cycle, drop the grant, update the last-granted flag, return to IDLE.
- PageCnt SHALL hold its final value until the next grant.
REQ-027 The timeout counter SHALL increment every cycle in WAIT_RDY and XFER.
- Reaching TIMEOUT SHALL go to ERR.
REQ-028 ERR: SHALL pulse Error for one cycle, drop the grant, update the last-granted flag, return to IDLE.
REQ-029 Request deassertion or changes to WrPages/RdPages after grant SHALL be ignored until IDLE.
REQ-030 PageCnt SHALL saturate at all-ones and never wrap; the count compare terminates transfers first.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 On nReset=0, asynchronously:
- state = IDLE;
- all strobes, grants, Busy, Done and Error = 0;
- PageCnt = 0; timeout counter = 0;
- latched count = 0; last-granted = read.
REQ-033 Reset mid-transfer SHALL abort without a Done or Error pulse.
- The first request after release SHALL be arbitrated normally.

Verification
REQ-034 WrReq=1, WrPages=3, ready=1 -> WrGrant at edge 1, WrStart pulse at edge 2; after three AckWr -> PageCnt=3, Done pulse, WrGrant=0, Busy=0.
REQ-035 WrReq=RdReq=1 from reset -> write is granted; after Done with both still high -> read is granted next.
REQ-036 RdReq=1, RdPages=0 -> Error pulse 1 cycle after grant, no RdStart.
REQ-037 Ready held low, TIMEOUT=16 -> Error pulse after 16 WAIT_RDY cycles, grant dropped, no start.
REQ-038 AckWr during a read transfer -> PageCnt unchanged; nReset low mid-XFER -> all outputs 0 immediately, no Done or Error.
